vram_write_sched: RTL and testbench
===================================

Name: vram_write_sched

Overview:
- Write-side scheduler for the text-mode video controller. It shares the single video write port (sig_write/addr/value) between the CPU store path and a hardware fill engine.
- The fill engine writes one constant value across an address range, for clear-screen and fill-line operations.
- Arbitration is round-robin. All outputs to the video controller are registered.
- Sits between the CPU memory-mapped decode and the video controller write interface, in the clk domain.

Parameters:
- SCREEN_BASE, 1024, first symbol-cell address (addresses below it are glyph table).
- SCREEN_CELLS, 5000, number of symbol cells (100 cols x 50 rows).
- ADDR_W, 13, video address width.
- DATA_W, 16, video data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_valid  in  1  CPU write request.
- cpu_addr  in  ADDR_W  CPU write address.
- cpu_value  in  DATA_W  CPU write data.
- cpu_ready  out  1  combinational grant; transfer occurs when cpu_valid & cpu_ready.
- fill_start  in  1  single-cycle pulse that starts a fill.
- fill_base  in  ADDR_W  fill start address, sampled on fill_start.
- fill_count  in  ADDR_W  number of words to write, sampled on fill_start.
- fill_value  in  DATA_W  fill data, sampled on fill_start.
- fill_abort  in  1  stops an active fill.
- fill_busy  out  1  fill engine is in RUN.
- fill_done  out  1  single-cycle completion pulse.
- err_clear  in  1  clears addr_err.
- addr_err  out  1  sticky out-of-range flag.
- vid_write  out  1  to the video controller sig_write.
- vid_addr  out  ADDR_W  to the video controller addr.
- vid_value  out  DATA_W  to the video controller value.

Behaviour:
- Reset state:
  - vid_write=0, vid_addr=0, vid_value=0.
  - fill_busy=0, fill_done=0, addr_err=0.
  - FSM=IDLE, last_grant=FILL, so the CPU wins the first tie.
- Requesters:
  - The CPU requests when cpu_valid=1.
  - The fill engine requests when state=RUN and fill_abort=0.
- Arbitration, evaluated combinationally each cycle:
  - Exactly one requester active: it is granted.
  - Both active: the one not equal to last_grant is granted.
  - last_grant updates only on a grant.
  - Under sustained contention the port alternates CPU, FILL, CPU, ...
- cpu_ready equals the CPU grant. The CPU must hold addr and value stable while cpu_valid=1 and cpu_ready=0.
- Latency:
  - A granted write appears on vid_write/vid_addr/vid_value at the next clk edge, for exactly 1 cycle.
  - vid_write=0 in any cycle with no grant. vid_addr and vid_value hold their last values.
- FSM IDLE:
  - fill_start with fill_count≠0: latch cur=fill_base, rem=fill_count, val=fill_value; go to RUN; fill_busy=1 next cycle.
  - fill_start with fill_count=0: stay IDLE; fill_done=1 next cycle.
- FSM RUN, on each fill grant:
  - Emit (cur, val); cur<=cur+1 modulo 2^ADDR_W (wraps 8191->0); rem<=rem-1.
  - The grant with rem=1 returns the FSM to IDLE. fill_done pulses in the same cycle the last write appears on vid_write, and fill_busy falls in that cycle.
- fill_start while RUN: ignored, no effect on the latched parameters.
- fill_abort while RUN:
  - FSM goes to IDLE next cycle, no fill_done pulse, no fill grant that cycle.
  - Writes already emitted remain.
  - fill_abort while IDLE has no effect.
- fill_start and fill_abort in the same IDLE cycle: the start wins.
- Reset mid-fill: asynchronous return to the reset state; the partial fill is not resumed.
- addr_err: cleared by err_clear (synchronous) or reset. If a set event and err_clear occur in the same cycle, the set wins.

Optional Feature:
- Macro: VRAM_WRITE_SCHED_ADDR_CHECK_EN.
- Defined:
  - A CPU write with cpu_addr >= SCREEN_BASE+SCREEN_CELLS (6024 with defaults) is still granted (cpu_ready asserted normally) but is dropped: vid_write stays 0 for it.
  - addr_err sets to 1 the next cycle.
  - Fill writes are never checked.
- Not defined: every CPU write is forwarded unchanged and addr_err is tied to 0.

Test Plan:
- CPU only: cpu_valid=1, addr=1024, value=0x0041 -> cpu_ready=1 same cycle; next cycle vid_write=1, vid_addr=1024, vid_value=0x0041; following cycle vid_write=0.
- Fill alone: fill_start, base=1024, count=5000, value=0x0020 -> 5000 consecutive vid_write cycles at addresses 1024..6023; fill_done pulses with the 6023 write; fill_busy then 0.
- Contention: fill base=2000, count=4 running while cpu_valid held with 3 back-to-back writes -> vid_write address sequence CPU, 2000, CPU, 2001, CPU, 2002, 2003; fill_done on 2003.
- Boundaries:
  - fill base=8190, count=3 -> writes to 8190, 8191, 0.
  - fill_count=0 -> fill_done next cycle, no vid_write, fill_busy stays 0.
- Abort and restart:
  - fill count=100, assert fill_abort after 10 writes -> no further fill writes, no fill_done, fill_busy=0.
  - fill_start during RUN -> ignored.
  - reset mid-fill -> all outputs 0 immediately.
- With VRAM_WRITE_SCHED_ADDR_CHECK_EN: CPU write addr=6024 -> cpu_ready=1, no vid_write, addr_err=1 next cycle; err_clear -> addr_err=0. Without the macro, the same write is forwarded to vid_addr=6024.

Source files
------------

// File: rtl/vram_write_sched.sv
// Write-port scheduler sharing the video write port between CPU stores and a fill engine.
// Define VRAM_WRITE_SCHED_ADDR_CHECK_EN to drop out-of-range CPU writes and flag them on addr_err.
module vram_write_sched #(
    parameter int SCREEN_BASE  = 1024,
    parameter int SCREEN_CELLS = 5000,
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_value,
    output logic              cpu_ready,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W-1:0] fill_count,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              fill_abort,
    output logic              fill_busy,
    output logic              fill_done,
    input  logic              err_clear,
    output logic              addr_err,
    output logic              vid_write,
    output logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_value
);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic {GRANT_CPU, GRANT_FILL} grant_t;

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(SCREEN_BASE + SCREEN_CELLS);

    state_t            state;
    grant_t            last_grant;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] rem;
    logic [DATA_W-1:0] val;

    logic fill_req;
    logic grant_cpu;
    logic grant_fill;
    logic cpu_drop;

    // Round-robin: on a tie the requester that did not win last time gets the port.
    assign fill_req   = (state == RUN) && !fill_abort;
    assign grant_cpu  = cpu_valid && (!fill_req || last_grant == GRANT_FILL);
    assign grant_fill = fill_req && (!cpu_valid || last_grant == GRANT_CPU);
    assign cpu_ready  = grant_cpu;
    assign fill_busy  = (state == RUN);

`ifdef VRAM_WRITE_SCHED_ADDR_CHECK_EN
    assign cpu_drop = cpu_addr >= ADDR_LIMIT;

    // A new out-of-range write outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_err <= 1'b0;
        end else if (grant_cpu && cpu_drop) begin
            addr_err <= 1'b1;
        end else if (err_clear) begin
            addr_err <= 1'b0;
        end
    end
`else
    logic unused_cfg;

    assign cpu_drop   = 1'b0;
    assign addr_err   = 1'b0;
    assign unused_cfg = &{1'b0, err_clear, ADDR_LIMIT};
`endif

    // NOTE: state is updated with non-blocking assignments so every branch below
    // sees the values from the start of the cycle, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GRANT_FILL;
            cur        <= '0;
            rem        <= '0;
            val        <= '0;
            vid_write  <= 1'b0;
            vid_addr   <= '0;
            vid_value  <= '0;
            fill_done  <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here so each one lasts a single cycle.
            vid_write <= 1'b0;
            fill_done <= 1'b0;

            if (grant_cpu) begin
                last_grant <= GRANT_CPU;
                if (!cpu_drop) begin
                    vid_write <= 1'b1;
                    vid_addr  <= cpu_addr;
                    vid_value <= cpu_value;
                end
            end else if (grant_fill) begin
                last_grant <= GRANT_FILL;
                vid_write  <= 1'b1;
                vid_addr   <= cur;
                vid_value  <= val;
                cur        <= cur + ADDR_W'(1);
                rem        <= rem - ADDR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (fill_start) begin
                        if (fill_count != '0) begin
                            cur   <= fill_base;
                            rem   <= fill_count;
                            val   <= fill_value;
                            state <= RUN;
                        end else begin
                            fill_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // An abort suppresses the fill request, so no fill grant races it.
                    if (fill_abort) begin
                        state <= IDLE;
                    end else if (grant_fill && rem == ADDR_W'(1)) begin
                        state     <= IDLE;
                        fill_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_write_sched.sv
// Scoreboard bench for vram_write_sched: directed stimulus queues expected video writes,
// a negedge monitor pops and compares them whenever vid_write or fill_done is seen.
module tb_vram_write_sched;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] value;
        logic              done;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              cpu_valid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_value;
    logic              cpu_ready;
    logic              fill_start;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W-1:0] fill_count;
    logic [DATA_W-1:0] fill_value;
    logic              fill_abort;
    logic              fill_busy;
    logic              fill_done;
    logic              err_clear;
    logic              addr_err;
    logic              vid_write;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_value;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic sb_en = 1'b1;

    vram_write_sched dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_valid  (cpu_valid),
        .cpu_addr   (cpu_addr),
        .cpu_value  (cpu_value),
        .cpu_ready  (cpu_ready),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_count (fill_count),
        .fill_value (fill_value),
        .fill_abort (fill_abort),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .err_clear  (err_clear),
        .addr_err   (addr_err),
        .vid_write  (vid_write),
        .vid_addr   (vid_addr),
        .vid_value  (vid_value)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic push_w(input int addr, input int value, input logic done);
        exp_t e;
        e.wr    = 1'b1;
        e.addr  = ADDR_W'(addr);
        e.value = DATA_W'(value);
        e.done  = done;
        sb_q.push_back(e);
    endtask

    task automatic push_done_only();
        exp_t e;
        e = '0;
        e.done = 1'b1;
        sb_q.push_back(e);
    endtask

    // Monitor: every observed write or done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && sb_en && (vid_write || fill_done)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_event", {vid_write, vid_addr, vid_value, fill_done}, 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_write", {31'h0, vid_write}, {31'h0, e.wr});
                check("sb_done", {31'h0, fill_done}, {31'h0, e.done});
                if (e.wr) begin
                    check("sb_addr", {19'h0, vid_addr}, {19'h0, e.addr});
                    check("sb_value", {16'h0, vid_value}, {16'h0, e.value});
                end
            end
        end
    end

    // All driver tasks start and end just after a rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fill(input int base, input int count, input int value, input logic with_abort);
        fill_start = 1'b1;
        fill_base  = ADDR_W'(base);
        fill_count = ADDR_W'(count);
        fill_value = DATA_W'(value);
        fill_abort = with_abort;
        next_cycle();
        fill_start = 1'b0;
        fill_abort = 1'b0;
    endtask

    task automatic cpu_write(input int addr, input int value);
        logic got;
        got = 1'b0;
        cpu_valid = 1'b1;
        cpu_addr  = ADDR_W'(addr);
        cpu_value = DATA_W'(value);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = cpu_ready;
        end
        if (!got) check("cpu_ready_timeout", 32'h0, 32'h1);
        next_cycle();
        cpu_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check(name, sb_q.size(), 0);
    endtask

    initial begin
        reset      = 1'b1;
        cpu_valid  = 1'b0;
        cpu_addr   = '0;
        cpu_value  = '0;
        fill_start = 1'b0;
        fill_base  = '0;
        fill_count = '0;
        fill_value = '0;
        fill_abort = 1'b0;
        err_clear  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vid_write", {31'h0, vid_write}, 32'h0);
        check("rst_vid_addr", {19'h0, vid_addr}, 32'h0);
        check("rst_vid_value", {16'h0, vid_value}, 32'h0);
        check("rst_fill_busy", {31'h0, fill_busy}, 32'h0);
        check("rst_fill_done", {31'h0, fill_done}, 32'h0);
        check("rst_addr_err", {31'h0, addr_err}, 32'h0);
        reset = 1'b0;
        next_cycle();

        // CPU alone: one-cycle write, address/value then hold.
        push_w(1024, 16'h0041, 1'b0);
        cpu_write(1024, 16'h0041);
        check("cpu_vid_write", {31'h0, vid_write}, 32'h1);
        next_cycle();
        check("cpu_write_gone", {31'h0, vid_write}, 32'h0);
        check("cpu_addr_hold", {19'h0, vid_addr}, 32'd1024);
        drain("drain_cpu", 10);

        // Full-screen clear.
        for (int a = 1024; a < 6024; a++) push_w(a, 16'h0020, a == 6023);
        start_fill(1024, 5000, 16'h0020, 1'b0);
        check("fill_busy_on", {31'h0, fill_busy}, 32'h1);
        drain("drain_fill", 6000);
        check("fill_busy_off", {31'h0, fill_busy}, 32'h0);

        // Contention: CPU wins first tie, then strict alternation.
        push_w(100, 16'hA001, 1'b0);
        push_w(2000, 16'h1111, 1'b0);
        push_w(101, 16'hA002, 1'b0);
        push_w(2001, 16'h1111, 1'b0);
        push_w(102, 16'hA003, 1'b0);
        push_w(2002, 16'h1111, 1'b0);
        push_w(2003, 16'h1111, 1'b1);
        start_fill(2000, 4, 16'h1111, 1'b0);
        cpu_write(100, 16'hA001);
        cpu_write(101, 16'hA002);
        cpu_write(102, 16'hA003);
        drain("drain_contention", 50);

        // Address wrap at the top of the video space.
        push_w(8190, 16'h2222, 1'b0);
        push_w(8191, 16'h2222, 1'b0);
        push_w(0, 16'h2222, 1'b1);
        start_fill(8190, 3, 16'h2222, 1'b0);
        drain("drain_wrap", 20);

        // Zero-length fill: done pulse only.
        push_done_only();
        start_fill(300, 0, 16'h9999, 1'b0);
        check("zero_busy", {31'h0, fill_busy}, 32'h0);
        drain("drain_zero", 10);

        // Abort after ten writes: no more writes, no done.
        for (int a = 3000; a < 3010; a++) push_w(a, 16'h3333, 1'b0);
        start_fill(3000, 100, 16'h3333, 1'b0);
        repeat (10) next_cycle();
        fill_abort = 1'b1;
        next_cycle();
        fill_abort = 1'b0;
        check("abort_busy", {31'h0, fill_busy}, 32'h0);
        repeat (5) next_cycle();
        check("abort_quiet", {31'h0, fill_busy}, 32'h0);
        drain("drain_abort", 10);

        // fill_start while running is ignored.
        push_w(4000, 16'h4444, 1'b0);
        push_w(4001, 16'h4444, 1'b0);
        push_w(4002, 16'h4444, 1'b1);
        start_fill(4000, 3, 16'h4444, 1'b0);
        start_fill(100, 50, 16'hDEAD, 1'b0);
        drain("drain_restart", 20);
        repeat (3) next_cycle();

        // Start and abort together in IDLE: start wins.
        push_w(500, 16'h5050, 1'b0);
        push_w(501, 16'h5050, 1'b1);
        start_fill(500, 2, 16'h5050, 1'b1);
        drain("drain_start_abort", 20);

        // Reset in the middle of a fill.
        sb_en = 1'b0;
        start_fill(5000, 100, 16'h6666, 1'b0);
        repeat (5) next_cycle();
        check("pre_reset_write", {31'h0, vid_write}, 32'h1);
        reset = 1'b1;
        #1;
        check("midrst_vid_write", {31'h0, vid_write}, 32'h0);
        check("midrst_vid_addr", {19'h0, vid_addr}, 32'h0);
        check("midrst_vid_value", {16'h0, vid_value}, 32'h0);
        check("midrst_fill_busy", {31'h0, fill_busy}, 32'h0);
        next_cycle();
        reset = 1'b0;
        sb_q.delete();
        sb_en = 1'b1;
        repeat (10) next_cycle();
        check("post_reset_busy", {31'h0, fill_busy}, 32'h0);

        // Screen upper boundary for CPU writes.
        push_w(6023, 16'h1234, 1'b0);
        cpu_write(6023, 16'h1234);
        drain("drain_6023", 10);
`ifdef VRAM_WRITE_SCHED_ADDR_CHECK_EN
        cpu_write(6024, 16'h5555);
        check("oor_dropped", {31'h0, vid_write}, 32'h0);
        check("oor_err_set", {31'h0, addr_err}, 32'h1);
        err_clear = 1'b1;
        next_cycle();
        err_clear = 1'b0;
        check("err_cleared", {31'h0, addr_err}, 32'h0);
        err_clear = 1'b1;
        cpu_write(6100, 16'h7777);
        err_clear = 1'b0;
        check("set_beats_clear", {31'h0, addr_err}, 32'h1);
        err_clear = 1'b1;
        next_cycle();
        err_clear = 1'b0;
        check("err_cleared2", {31'h0, addr_err}, 32'h0);
`else
        push_w(6024, 16'h5555, 1'b0);
        cpu_write(6024, 16'h5555);
        check("oor_forwarded", {31'h0, vid_write}, 32'h1);
        check("oor_no_err", {31'h0, addr_err}, 32'h0);
`endif
        drain("drain_final", 20);
        repeat (3) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
